// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised rx, start-glitch rejection, optional parity,
// 1/2 stop bits, parity/framing/overrun reporting and a valid/ready output handshake.
module uart_rx_cfg #(
    parameter int CLK_PER_BAUD = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_PER_BAUD);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID   = CW'((CLK_PER_BAUD - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BAUD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Expected parity bit for the received data word (odd or even sense).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            parity_bit = ~(^d);
        end else begin
            parity_bit = ^d;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_pend_q, perr_pend_d;
    logic                   ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   rxs_s;
    logic                   fall_s;
    logic                   done_s;

    assign rxs_s = sync_q[SYNC_STAGES-1];
    // The fill chain marks when rxs reflects the real line, so a line held low out of
    // reset is never mistaken for a start edge: the line must be seen high first.
    assign fall_s = armed_q & rxs_prev_q & ~rxs_s;

    // Next-state logic for synchroniser, frame FSM and output handshake.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], rx};
        fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d      = armed_q | (fill_q[SYNC_STAGES-1] & rxs_s);
        rxs_prev_d   = rxs_s;
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        perr_pend_d  = perr_pend_q;
        ferr_pend_d  = ferr_pend_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        done_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall_s) begin
                    state_d   = S_START;
                    clk_cnt_d = CNT_ZERO;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_START: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = CNT_ZERO;
                    if (rxs_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_DATA;
                        bit_idx_d   = IDX_ZERO;
                        perr_pend_d = 1'b0;
                        ferr_pend_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = CNT_ZERO;
                    shift_d[bit_idx_q] = rxs_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d  = bit_idx_q + IDX_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            S_PARITY: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d   = CNT_ZERO;
                    perr_pend_d = (rxs_s != parity_bit(shift_q));
                    state_d     = S_STOP;
                    stop_idx_d  = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d   = CNT_ZERO;
                    ferr_pend_d = ferr_pend_q | ~rxs_s;
                    if (stop_idx_q == STOP_LAST) begin
                        done_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A completed frame is dropped (with an overrun pulse) if the held word is not leaving.
        if (done_s) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = perr_pend_d;
                frame_err_d  = ferr_pend_d;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            sync_q       <= {SYNC_STAGES{1'b1}};
            fill_q       <= {SYNC_STAGES{1'b0}};
            armed_q      <= 1'b0;
            rxs_prev_q   <= 1'b1;
            clk_cnt_q    <= CNT_ZERO;
            bit_idx_q    <= IDX_ZERO;
            stop_idx_q   <= 1'b0;
            shift_q      <= {DATA_BITS{1'b0}};
            perr_pend_q  <= 1'b0;
            ferr_pend_q  <= 1'b0;
            rx_data_q    <= {DATA_BITS{1'b0}};
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            rxs_prev_q   <= rxs_prev_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            perr_pend_q  <= perr_pend_d;
            ferr_pend_q  <= ferr_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
